esfa_op_sequencer: RTL and testbench

Front-end controller for the 8-cell ESFA memory array and its combinator tree. It accepts one host operation at a time over a valid/ready request channel and drives the array's index/value/metadata/selector lines for a fixed issue-plus-settle window. It then captures the tree's resultBool/resultValue and returns them on a valid/ready response channel. After every reset it runs an initialisation sweep that writes 0 to every cell before it accepts host traffic.

---
 rtl/esfa_pkg.sv | 26 ++
 rtl/esfa_op_sequencer_if.sv | 32 +++
 rtl/esfa_rsp_reg.sv | 68 ++++++
 rtl/esfa_op_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_esfa_op_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA operation sequencer.
// Holds the op encodings, the idle selector code, the FSM state type
// and the default widths and timing used by the sequencer and its host interface.
package esfa_pkg;

  localparam int IDX_W             = 8;
  localparam int VAL_W             = 8;
  localparam int DEF_NUM_CELLS     = 8;
  localparam int DEF_SETTLE_CYCLES = 2;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_META   = 2'd2;
  localparam logic [1:0] OP_LOOKUP = 2'd3;

  localparam logic [VAL_W-1:0] SEL_IDLE = 8'hFF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/esfa_op_sequencer_if.sv
// Host request/response channel of the ESFA sequencer.
// Request: req_valid/req_ready plus op, index, value, meta and selector.
// Response: rsp_valid/rsp_ready plus op echo, bool, value and err.
// The master modport is the host side; the slave modport is the sequencer side.
interface esfa_op_sequencer_if;
  import esfa_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_index;
  logic [VAL_W-1:0] req_value;
  logic [VAL_W-1:0] req_meta;
  logic [VAL_W-1:0] req_selector;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_op;
  logic             rsp_bool;
  logic [VAL_W-1:0] rsp_value;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_index, req_value, req_meta, req_selector, rsp_ready,
    input  req_ready, rsp_valid, rsp_op, rsp_bool, rsp_value, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_index, req_value, req_meta, req_selector, rsp_ready,
    output req_ready, rsp_valid, rsp_op, rsp_bool, rsp_value, rsp_err
  );

endinterface

// File: rtl/esfa_rsp_reg.sv
// Response holding register with a valid/ready output.
// Ports: clk, reset (async, active high); load plus the ld_* fields written
// on load; rsp_ready from the host; rsp_valid and the rsp_* fields to the host.
// The fields stay stable from load until the rsp_valid & rsp_ready handshake.
module esfa_rsp_reg
  import esfa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [1:0]       ld_op,
  input  logic             ld_bool,
  input  logic [VAL_W-1:0] ld_value,
  input  logic             ld_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [1:0]       rsp_op,
  output logic             rsp_bool,
  output logic [VAL_W-1:0] rsp_value,
  output logic             rsp_err
);

  logic             valid_q, valid_d;
  logic [1:0]       op_q, op_d;
  logic             bool_q, bool_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    bool_d  = bool_q;
    value_d = value_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      op_d    = ld_op;
      bool_d  = ld_bool;
      value_d = ld_value;
      err_d   = ld_err;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= 2'd0;
      bool_q  <= 1'b0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      bool_q  <= bool_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_op    = op_q;
  assign rsp_bool  = bool_q;
  assign rsp_value = value_q;
  assign rsp_err   = err_q;

endmodule

// File: rtl/esfa_op_sequencer.sv
// Front-end sequencer for the 8-cell ESFA array and its combinator tree.
// Ports: clk, reset (async, active high); host (request/response channel,
// slave side); arr_* drive lines to the array and result lines from the tree
// root; init_done (zero sweep finished); busy (not in IDLE).
//
// state  | meaning
// INIT   | zero sweep, one cell per cycle
// IDLE   | req_ready high, waiting for a request
// ISSUE  | drive the latched op onto the array lines
// SETTLE | hold the drive while the array registers it and the tree settles
// RESP   | response presented, waiting for rsp_ready
module esfa_op_sequencer
  import esfa_pkg::*;
#(
  parameter int NUM_CELLS     = DEF_NUM_CELLS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  esfa_op_sequencer_if.slave host,
  output logic [IDX_W-1:0] arr_new_index,
  output logic [VAL_W-1:0] arr_new_value,
  output logic [VAL_W-1:0] arr_metadata,
  output logic             arr_isMetadata,
  output logic [VAL_W-1:0] arr_selector,
  input  logic             arr_resultBool,
  input  logic [VAL_W-1:0] arr_resultValue,
  output logic             init_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W-1:0] meta_q, meta_d;
  logic [VAL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] a_index_q, a_index_d;
  logic [VAL_W-1:0] a_value_q, a_value_d;
  logic [VAL_W-1:0] a_meta_q, a_meta_d;
  logic             a_is_meta_q, a_is_meta_d;
  logic [VAL_W-1:0] a_sel_q, a_sel_d;
  logic             init_done_q, init_done_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  logic             rsp_load;
  logic [1:0]       ld_op;
  logic             ld_bool;
  logic [VAL_W-1:0] ld_value;
  logic             ld_err;
  logic             in_range;

  // Full-width unsigned compare so out-of-range indices never alias onto a cell.
  assign in_range = 32'(host.req_index) < NUM_CELLS;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    settle_cnt_d = settle_cnt_q;
    op_d         = op_q;
    index_d      = index_q;
    value_d      = value_q;
    meta_d       = meta_q;
    sel_d        = sel_q;
    a_index_d    = a_index_q;
    a_value_d    = a_value_q;
    a_meta_d     = a_meta_q;
    a_is_meta_d  = a_is_meta_q;
    a_sel_d      = a_sel_q;
    init_done_d  = init_done_q;
    rsp_load     = 1'b0;
    ld_op        = op_q;
    ld_bool      = 1'b0;
    ld_value     = '0;
    ld_err       = 1'b0;

    case (state_q)
      ST_INIT: begin
        a_value_d   = '0;
        a_is_meta_d = 1'b0;
        a_sel_d     = SEL_IDLE;
        if (init_cnt_q == IDX_W'(NUM_CELLS - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + IDX_W'(1);
          a_index_d  = init_cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          op_d    = host.req_op;
          index_d = host.req_index;
          value_d = host.req_value;
          meta_d  = host.req_meta;
          sel_d   = host.req_selector;
          ld_op   = host.req_op;
          if (host.req_op == OP_NOP) begin
            rsp_load = 1'b1;
            state_d  = ST_RESP;
          end else if (host.req_op == OP_LOOKUP || in_range) begin
            state_d = ST_ISSUE;
          end else begin
            rsp_load = 1'b1;
            ld_err   = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        case (op_q)
          OP_WRITE: begin
            a_index_d   = index_q;
            a_value_d   = value_q;
            a_is_meta_d = 1'b0;
            a_sel_d     = SEL_IDLE;
          end
          OP_META: begin
            a_index_d   = index_q;
            a_meta_d    = meta_q;
            a_is_meta_d = 1'b1;
            a_sel_d     = SEL_IDLE;
          end
          OP_LOOKUP: a_sel_d = sel_q;
          default: ;
        endcase
        // One cycle for the array to take the drive, then SETTLE_CYCLES for the tree.
        settle_cnt_d = CNT_W'(SETTLE_CYCLES);
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          rsp_load    = 1'b1;
          ld_bool     = arr_resultBool;
          ld_value    = arr_resultValue;
          a_sel_d     = SEL_IDLE;
          a_is_meta_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          settle_cnt_d = settle_cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (host.rsp_valid && host.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      settle_cnt_q <= '0;
      op_q         <= 2'd0;
      index_q      <= '0;
      value_q      <= '0;
      meta_q       <= '0;
      sel_q        <= '0;
      a_index_q    <= '0;
      a_value_q    <= '0;
      a_meta_q     <= '0;
      a_is_meta_q  <= 1'b0;
      a_sel_q      <= SEL_IDLE;
      init_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      op_q         <= op_d;
      index_q      <= index_d;
      value_q      <= value_d;
      meta_q       <= meta_d;
      sel_q        <= sel_d;
      a_index_q    <= a_index_d;
      a_value_q    <= a_value_d;
      a_meta_q     <= a_meta_d;
      a_is_meta_q  <= a_is_meta_d;
      a_sel_q      <= a_sel_d;
      init_done_q  <= init_done_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  esfa_rsp_reg u_rsp_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (rsp_load),
    .ld_op     (ld_op),
    .ld_bool   (ld_bool),
    .ld_value  (ld_value),
    .ld_err    (ld_err),
    .rsp_ready (host.rsp_ready),
    .rsp_valid (host.rsp_valid),
    .rsp_op    (host.rsp_op),
    .rsp_bool  (host.rsp_bool),
    .rsp_value (host.rsp_value),
    .rsp_err   (host.rsp_err)
  );

  assign host.req_ready  = req_ready_q;
  assign arr_new_index   = a_index_q;
  assign arr_new_value   = a_value_q;
  assign arr_metadata    = a_meta_q;
  assign arr_isMetadata  = a_is_meta_q;
  assign arr_selector    = a_sel_q;
  assign init_done       = init_done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Directed bench for esfa_op_sequencer: init sweep, write, meta, lookup,
// NOP, out-of-range errors, response back-pressure and reset mid-operation.
module tb_esfa_op_sequencer;
  import esfa_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [IDX_W-1:0] arr_new_index;
  logic [VAL_W-1:0] arr_new_value;
  logic [VAL_W-1:0] arr_metadata;
  logic             arr_isMetadata;
  logic [VAL_W-1:0] arr_selector;
  logic             arr_resultBool;
  logic [VAL_W-1:0] arr_resultValue;
  logic             init_done;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  esfa_op_sequencer_if bus ();

  esfa_op_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .host            (bus),
    .arr_new_index   (arr_new_index),
    .arr_new_value   (arr_new_value),
    .arr_metadata    (arr_metadata),
    .arr_isMetadata  (arr_isMetadata),
    .arr_selector    (arr_selector),
    .arr_resultBool  (arr_resultBool),
    .arr_resultValue (arr_resultValue),
    .init_done       (init_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val,
                      input logic [7:0] meta, input logic [7:0] sel);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_index    = idx;
    bus.req_value    = val;
    bus.req_meta     = meta;
    bus.req_selector = sel;
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'd0;
    bus.req_index   = '0;
    bus.req_value   = '0;
    bus.req_meta    = '0;
    bus.req_selector= '0;
    bus.rsp_ready   = 1'b0;
    arr_resultBool  = 1'b0;
    arr_resultValue = '0;
    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_selector", 32'(arr_selector), 32'hFF);
    chk("rst_index", 32'(arr_new_index), 0);
    chk("rst_busy", 32'(busy), 1);
    tick(); tick();
    reset = 1'b0;

    // Init sweep: index 0..7, value 0, one cycle each.
    for (int k = 0; k < 8; k++) begin
      chk("init_index", 32'(arr_new_index), 32'(k));
      chk("init_value", 32'(arr_new_value), 0);
      chk("init_sel", 32'(arr_selector), 32'hFF);
      chk("init_done_low", 32'(init_done), 0);
      chk("init_ready_low", 32'(bus.req_ready), 0);
      tick();
    end
    chk("init_done_high", 32'(init_done), 1);
    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_busy", 32'(busy), 0);

    // WRITE index 3, value 5A.
    bus.rsp_ready = 1'b1;
    send(OP_WRITE, 8'd3, 8'h5A, 8'h00, 8'h00);
    tick();                                   // T
    bus.req_valid = 1'b0;
    chk("wr_ready_low", 32'(bus.req_ready), 0);
    chk("wr_busy", 32'(busy), 1);
    tick();                                   // T+1
    chk("wr_index", 32'(arr_new_index), 3);
    chk("wr_value", 32'(arr_new_value), 32'h5A);
    chk("wr_ismeta", 32'(arr_isMetadata), 0);
    chk("wr_sel", 32'(arr_selector), 32'hFF);
    tick();                                   // T+2
    chk("wr_valid_t2", 32'(bus.rsp_valid), 0);
    tick();                                   // T+3
    chk("wr_valid_t3", 32'(bus.rsp_valid), 0);
    tick();                                   // T+4
    chk("wr_valid_t4", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_op", 32'(bus.rsp_op), 1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 0);
    tick();
    chk("wr_done_valid", 32'(bus.rsp_valid), 0);
    chk("wr_done_ready", 32'(bus.req_ready), 1);

    // LOOKUP selector 12, tree result 1/5A during settle.
    send(OP_LOOKUP, 8'd0, 8'h00, 8'h00, 8'h12);
    tick();                                   // T
    bus.req_valid = 1'b0;
    tick();                                   // T+1
    chk("lk_sel", 32'(arr_selector), 32'h12);
    chk("lk_index_held", 32'(arr_new_index), 3);
    arr_resultBool  = 1'b1;
    arr_resultValue = 8'h5A;
    tick(); tick();                           // T+3
    chk("lk_valid_t3", 32'(bus.rsp_valid), 0);
    tick();                                   // T+4
    chk("lk_valid_t4", 32'(bus.rsp_valid), 1);
    chk("lk_bool", 32'(bus.rsp_bool), 1);
    chk("lk_value", 32'(bus.rsp_value), 32'h5A);
    chk("lk_op", 32'(bus.rsp_op), 3);
    chk("lk_sel_idle", 32'(arr_selector), 32'hFF);
    tick();

    // META index 5, metadata 3C.
    send(OP_META, 8'd5, 8'h00, 8'h3C, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    tick();                                   // T+1
    chk("mt_ismeta", 32'(arr_isMetadata), 1);
    chk("mt_meta", 32'(arr_metadata), 32'h3C);
    chk("mt_index", 32'(arr_new_index), 5);
    chk("mt_value_held", 32'(arr_new_value), 32'h5A);
    tick(); tick(); tick();                   // T+4
    chk("mt_valid", 32'(bus.rsp_valid), 1);
    chk("mt_ismeta_idle", 32'(arr_isMetadata), 0);
    chk("mt_op", 32'(bus.rsp_op), 2);
    tick();

    // WRITE index 9: error response one cycle after handshake, array untouched.
    send(OP_WRITE, 8'd9, 8'h77, 8'h00, 8'h00);
    tick();                                   // T
    bus.req_valid = 1'b0;
    chk("er_valid", 32'(bus.rsp_valid), 1);
    chk("er_err", 32'(bus.rsp_err), 1);
    chk("er_value", 32'(bus.rsp_value), 0);
    chk("er_bool", 32'(bus.rsp_bool), 0);
    tick();
    chk("er_index_kept", 32'(arr_new_index), 5);
    chk("er_value_kept", 32'(arr_new_value), 32'h5A);
    chk("er_sel_idle", 32'(arr_selector), 32'hFF);
    chk("er_ready", 32'(bus.req_ready), 1);

    // META index 8 is the first illegal index.
    send(OP_META, 8'd8, 8'h00, 8'h99, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    chk("er8_err", 32'(bus.rsp_err), 1);
    chk("er8_op", 32'(bus.rsp_op), 2);
    tick();
    chk("er8_ismeta", 32'(arr_isMetadata), 0);
    chk("er8_meta_kept", 32'(arr_metadata), 32'h3C);

    // NOP.
    send(OP_NOP, 8'd0, 8'h00, 8'h00, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    chk("nop_valid", 32'(bus.rsp_valid), 1);
    chk("nop_op", 32'(bus.rsp_op), 0);
    chk("nop_err", 32'(bus.rsp_err), 0);
    tick();

    // Back-pressure: LOOKUP held for 5 cycles with a WRITE request waiting.
    bus.rsp_ready   = 1'b0;
    arr_resultBool  = 1'b0;
    arr_resultValue = 8'hA5;
    send(OP_LOOKUP, 8'd0, 8'h00, 8'h00, 8'h44);
    tick();                                   // T
    send(OP_WRITE, 8'd1, 8'h11, 8'h00, 8'h00);
    tick(); tick(); tick(); tick();           // T+4
    chk("bp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_value", 32'(bus.rsp_value), 32'hA5);
    arr_resultBool  = 1'b1;
    arr_resultValue = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_value", 32'(bus.rsp_value), 32'hA5);
      chk("bp_hold_bool", 32'(bus.rsp_bool), 0);
      chk("bp_hold_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();                                   // response handshake
    chk("bp_rel_valid", 32'(bus.rsp_valid), 0);
    chk("bp_rel_ready", 32'(bus.req_ready), 1);
    tick();                                   // WRITE accepted here
    bus.req_valid = 1'b0;
    chk("bp_next_accept", 32'(bus.req_ready), 0);
    chk("bp_next_busy", 32'(busy), 1);
    tick();                                   // drive out, now settling
    chk("bp_next_index", 32'(arr_new_index), 1);
    chk("bp_next_value", 32'(arr_new_value), 32'h11);

    // Reset during SETTLE aborts the op and reruns the sweep.
    reset = 1'b1;
    #1;
    chk("ab_valid", 32'(bus.rsp_valid), 0);
    chk("ab_init_done", 32'(init_done), 0);
    chk("ab_index", 32'(arr_new_index), 0);
    chk("ab_ready", 32'(bus.req_ready), 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ab_sweep_index", 32'(arr_new_index), 32'(k));
      chk("ab_sweep_valid", 32'(bus.rsp_valid), 0);
      tick();
    end
    chk("ab_init_done_high", 32'(init_done), 1);
    chk("ab_ready_high", 32'(bus.req_ready), 1);
    chk("ab_no_rsp", 32'(bus.rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
